drive_enve_addr_sequencer: RTL and testbench

- Parametrised successor to the drive-circuit envelope-memory control FSM (Horse Ridge style).
- Accepts envelope instructions (start address plus length) from the instruction table.
- Generates the per-cycle envelope-memory read address internally and flags the final sample itself.
- Holds one pending instruction, so back-to-back pulses play with no bubble; supports abort.

---
 rtl/drive_enve_addr_sequencer.sv | 159 +++++++++++++++
 tb/tb_drive_enve_addr_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/drive_enve_addr_sequencer.sv
// Envelope-memory read-address sequencer: plays (start, length) instructions with one pending slot.
// Optional DRIVE_ENVE_LOOP_EN adds the inst_loop port (each envelope plays inst_loop+1 passes).
module drive_enve_addr_sequencer #(
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 8,
   parameter int LOOP_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_inst_table_in,
   input  logic [ADDR_WIDTH-1:0] inst_start_addr,
   input  logic [LEN_WIDTH-1:0]  inst_length,
`ifdef DRIVE_ENVE_LOOP_EN
   input  logic [LOOP_WIDTH-1:0] inst_loop,
`endif
   output logic                  inst_ready,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] enve_memory_addr,
   output logic                  addr_valid,
   output logic                  start_read_addr,
   output logic                  is_read_env_fin,
   output logic                  busy
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, cur_start_q, cur_start_d, pend_addr_q, pend_addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d, cur_len_q, cur_len_d, pend_len_q, pend_len_d;
   logic [LOOP_WIDTH-1:0] loop_cnt_q, loop_cnt_d, pend_loop_q, pend_loop_d;
   logic                  valid_q, valid_d, start_q, start_d, fin_q, fin_d;
   logic                  pend_valid_q, pend_valid_d, busy_q, busy_d;
   logic [LOOP_WIDTH-1:0] loop_in;
   logic                  acc_nz, ld;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [LEN_WIDTH-1:0]  ld_len;
   logic [LOOP_WIDTH-1:0] ld_loop;

`ifdef DRIVE_ENVE_LOOP_EN
   assign loop_in = inst_loop;
`else
   assign loop_in = '0;
`endif

   assign inst_ready = !pend_valid_q && !abort;
   // Zero-length instructions are accepted but never reach pending or RUN.
   assign acc_nz     = valid_inst_table_in && inst_ready && (inst_length != '0);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      loop_cnt_d   = loop_cnt_q;
      cur_start_d  = cur_start_q;
      cur_len_d    = cur_len_q;
      valid_d      = valid_q;
      start_d      = 1'b0;
      fin_d        = 1'b0;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_len_d   = pend_len_q;
      pend_loop_d  = pend_loop_q;
      ld           = 1'b0;
      ld_addr      = inst_start_addr;
      ld_len       = inst_length;
      ld_loop      = loop_in;
      if (abort) begin
         state_d      = S_IDLE;
         valid_d      = 1'b0;
         pend_valid_d = 1'b0;
      end else if (state_q == S_IDLE) begin
         if (acc_nz) ld = 1'b1;
         else        valid_d = 1'b0;
      end else if (rem_q != '0 || loop_cnt_q != '0) begin
         if (rem_q != '0) begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            fin_d  = (rem_q == LEN_WIDTH'(1)) && (loop_cnt_q == '0);
         end else begin
            // Next pass of a looped envelope restarts without a start pulse.
            addr_d     = cur_start_q;
            rem_d      = cur_len_q - 1'b1;
            loop_cnt_d = loop_cnt_q - 1'b1;
            fin_d      = (cur_len_q == LEN_WIDTH'(1)) && (loop_cnt_q == LOOP_WIDTH'(1));
         end
         if (acc_nz) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = inst_start_addr;
            pend_len_d   = inst_length;
            pend_loop_d  = loop_in;
         end
      end else if (pend_valid_q) begin
         ld           = 1'b1;
         ld_addr      = pend_addr_q;
         ld_len       = pend_len_q;
         ld_loop      = pend_loop_q;
         pend_valid_d = 1'b0;
      end else if (acc_nz) begin
         ld = 1'b1;
      end else begin
         state_d = S_IDLE;
         valid_d = 1'b0;
      end
      if (ld) begin
         state_d     = S_RUN;
         addr_d      = ld_addr;
         rem_d       = ld_len - 1'b1;
         loop_cnt_d  = ld_loop;
         cur_start_d = ld_addr;
         cur_len_d   = ld_len;
         valid_d     = 1'b1;
         start_d     = 1'b1;
         fin_d       = (ld_len == LEN_WIDTH'(1)) && (ld_loop == '0);
      end
      busy_d = (state_d == S_RUN) || pend_valid_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         loop_cnt_q   <= '0;
         cur_start_q  <= '0;
         cur_len_q    <= '0;
         valid_q      <= 1'b0;
         start_q      <= 1'b0;
         fin_q        <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_len_q   <= '0;
         pend_loop_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         loop_cnt_q   <= loop_cnt_d;
         cur_start_q  <= cur_start_d;
         cur_len_q    <= cur_len_d;
         valid_q      <= valid_d;
         start_q      <= start_d;
         fin_q        <= fin_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_len_q   <= pend_len_d;
         pend_loop_q  <= pend_loop_d;
         busy_q       <= busy_d;
      end
   end

   assign enve_memory_addr = addr_q;
   assign addr_valid       = valid_q;
   assign start_read_addr  = start_q;
   assign is_read_env_fin  = fin_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_drive_enve_addr_sequencer.sv
// Directed bench for drive_enve_addr_sequencer with an expected-sample scoreboard.
module tb_drive_enve_addr_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid_inst_table_in = 1'b0;
   logic [9:0] inst_start_addr = '0;
   logic [7:0] inst_length = '0;
`ifdef DRIVE_ENVE_LOOP_EN
   logic [3:0] inst_loop = '0;
`endif
   logic       inst_ready;
   logic       abort = 1'b0;
   logic [9:0] enve_memory_addr;
   logic       addr_valid, start_read_addr, is_read_env_fin, busy;

   typedef struct {
      logic [9:0] a;
      logic       s;
      logic       f;
   } smp_t;

   smp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   drive_enve_addr_sequencer dut (
      .clk                 (clk),
      .rst                 (rst),
      .valid_inst_table_in (valid_inst_table_in),
      .inst_start_addr     (inst_start_addr),
      .inst_length         (inst_length),
`ifdef DRIVE_ENVE_LOOP_EN
      .inst_loop           (inst_loop),
`endif
      .inst_ready          (inst_ready),
      .abort               (abort),
      .enve_memory_addr    (enve_memory_addr),
      .addr_valid          (addr_valid),
      .start_read_addr     (start_read_addr),
      .is_read_env_fin     (is_read_env_fin),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [9:0] a, input logic s, input logic f);
      smp_t e;
      e.a = a; e.s = s; e.f = f;
      exp_q.push_back(e);
   endtask

   task automatic expect_instr(input logic [9:0] st, input int len, input int passes);
      for (int p = 0; p < passes; p++)
         for (int i = 0; i < len; i++)
            push(st + 10'(i), (p == 0) && (i == 0), (p == passes - 1) && (i == len - 1));
   endtask

   // Drives one instruction for a single accepting edge; returns 1 ns after that edge.
   task automatic send(input logic [9:0] st, input logic [7:0] len, input logic [3:0] lp);
      valid_inst_table_in = 1'b1;
      inst_start_addr     = st;
      inst_length         = len;
`ifdef DRIVE_ENVE_LOOP_EN
      inst_loop           = lp;
`else
      if (lp != 4'd0) $display("loop count ignored in this build");
`endif
      #1 check("ready_at_accept", inst_ready, 1);
      @(posedge clk);
      #1 valid_inst_table_in = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy && !addr_valid) break;
      end
      check(tag, {busy, addr_valid}, 0);
   endtask

   // Scoreboard monitor: every live sample must match the next expected one.
   always @(negedge clk) begin
      if (!rst) begin
         if (addr_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_sample", enve_memory_addr, 10'h3ff);
            end else begin
               smp_t e;
               e = exp_q.pop_front();
               check("sb_addr", enve_memory_addr, e.a);
               check("sb_start", start_read_addr, e.s);
               check("sb_fin", is_read_env_fin, e.f);
            end
         end else if (start_read_addr || is_read_env_fin) begin
            check("pulse_without_valid", {start_read_addr, is_read_env_fin}, 0);
         end
      end
   end

   initial begin
      // Reset state
      #22;
      check("rst_addr_valid", addr_valid, 0);
      check("rst_addr", enve_memory_addr, 0);
      check("rst_pulses", {start_read_addr, is_read_env_fin}, 0);
      check("rst_busy", busy, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", inst_ready, 1);

      // Idle accept
      expect_instr(10'd5, 3, 1);
      send(10'd5, 8'd3, 4'd0);
      @(negedge clk);
      check("idle_first_addr", enve_memory_addr, 5);
      check("idle_first_start", start_read_addr, 1);
      wait_idle("idle_done");
      check("addr_hold", enve_memory_addr, 7);
      @(posedge clk); #1;

      // Back-to-back with pending instruction
      expect_instr(10'd0, 4, 1);
      expect_instr(10'd100, 2, 1);
      send(10'd0, 8'd4, 4'd0);
      send(10'd100, 8'd2, 4'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) check("ready_low_pending", inst_ready, 0);
         check("b2b_contiguous", addr_valid, 1);
      end
      @(negedge clk);
      check("b2b_end", addr_valid, 0);
      wait_idle("b2b_idle");
      @(posedge clk); #1;

      // Address wrap, then length 1
      expect_instr(10'd1022, 4, 1);
      send(10'd1022, 8'd4, 4'd0);
      wait_idle("wrap_idle");
      @(posedge clk); #1;
      expect_instr(10'd9, 1, 1);
      send(10'd9, 8'd1, 4'd0);
      @(negedge clk);
      check("len1_pulses", {start_read_addr, is_read_env_fin}, 2'b11);
      wait_idle("len1_idle");
      @(posedge clk); #1;

      // Maximum length
      expect_instr(10'd500, 255, 1);
      send(10'd500, 8'd255, 4'd0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!addr_valid) break;
      end
      check("maxlen_drained", exp_q.size(), 0);
      wait_idle("maxlen_idle");
      @(posedge clk); #1;

      // Zero length
      send(10'd33, 8'd0, 4'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("zero_len_idle", {busy, addr_valid}, 0);
      end
      @(posedge clk); #1;

      // Abort with pending present
      push(10'd200, 1'b1, 1'b0);
      push(10'd201, 1'b0, 1'b0);
      push(10'd202, 1'b0, 1'b0);
      send(10'd200, 8'd10, 4'd0);
      send(10'd300, 8'd5, 4'd0);
      @(posedge clk); #1;
      abort = 1'b1;
      #1 check("ready_during_abort", inst_ready, 0);
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_valid", addr_valid, 0);
      check("abort_fin", is_read_env_fin, 0);
      check("abort_busy", busy, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_pending_gone", addr_valid, 0);
      end
      @(posedge clk); #1;

`ifdef DRIVE_ENVE_LOOP_EN
      expect_instr(10'd20, 2, 3);
      send(10'd20, 8'd2, 4'd2);
      wait_idle("loop_idle");
      @(posedge clk); #1;
`endif

      // Reset mid-RUN with a pending instruction
      push(10'd400, 1'b1, 1'b0);
      push(10'd401, 1'b0, 1'b0);
      send(10'd400, 8'd10, 4'd0);
      send(10'd600, 8'd3, 4'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", addr_valid, 0);
      check("async_rst_addr", enve_memory_addr, 0);
      check("async_rst_busy", busy, 0);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      check("rst_pending_lost", {busy, addr_valid}, 0);
      check("sb_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
